// File: rtl/cc_mux_rr_if.sv
// Channel-side and output-side signals of the cc_mux_rr arbitrating multiplexer.
// The slave modport is the mux's view; master is the environment's view.
interface cc_mux_rr_if #(
  parameter int unsigned NUMBER_DATAWIDTH = 8,
  parameter int unsigned NUMBER_CHANNELS  = 4,
  parameter int unsigned NUMBER_SELWIDTH  = 2
);
  logic                                        CC_MUX_RR_mode_In;
  logic [NUMBER_SELWIDTH-1:0]                  CC_MUX_RR_select_InBUS;
  logic [NUMBER_CHANNELS*NUMBER_DATAWIDTH-1:0] CC_MUX_RR_data_InBUS;
  logic [NUMBER_CHANNELS-1:0]                  CC_MUX_RR_valid_InBUS;
  logic [NUMBER_CHANNELS-1:0]                  CC_MUX_RR_ready_OutBUS;
  logic [NUMBER_DATAWIDTH-1:0]                 CC_MUX_RR_z_Out;
  logic [NUMBER_SELWIDTH-1:0]                  CC_MUX_RR_channel_Out;
  logic                                        CC_MUX_RR_valid_Out;
  logic                                        CC_MUX_RR_ready_In;

  modport slave (
    input  CC_MUX_RR_mode_In,
    input  CC_MUX_RR_select_InBUS,
    input  CC_MUX_RR_data_InBUS,
    input  CC_MUX_RR_valid_InBUS,
    input  CC_MUX_RR_ready_In,
    output CC_MUX_RR_ready_OutBUS,
    output CC_MUX_RR_z_Out,
    output CC_MUX_RR_channel_Out,
    output CC_MUX_RR_valid_Out
  );

  modport master (
    output CC_MUX_RR_mode_In,
    output CC_MUX_RR_select_InBUS,
    output CC_MUX_RR_data_InBUS,
    output CC_MUX_RR_valid_InBUS,
    output CC_MUX_RR_ready_In,
    input  CC_MUX_RR_ready_OutBUS,
    input  CC_MUX_RR_z_Out,
    input  CC_MUX_RR_channel_Out,
    input  CC_MUX_RR_valid_Out
  );
endinterface

// File: rtl/cc_mux_rr.sv
// N-channel valid/ready multiplexer with fixed-select or round-robin arbitration
// and a single registered output stage.
module cc_mux_rr #(
  parameter int unsigned NUMBER_DATAWIDTH = 8,
  parameter int unsigned NUMBER_CHANNELS  = 4,
  parameter int unsigned NUMBER_SELWIDTH  = 2
) (
  input logic        CC_MUX_RR_CLOCK_50,
  input logic        CC_MUX_RR_RESET_InLow,
  cc_mux_rr_if.slave bus
);

  logic [NUMBER_SELWIDTH-1:0]  ptrQ, ptrD;
  logic [NUMBER_SELWIDTH-1:0]  chanQ, chanD;
  logic [NUMBER_DATAWIDTH-1:0] zQ, zD;
  logic                        validQ, validD;

  logic                        grantValid;
  logic [NUMBER_SELWIDTH-1:0]  grantIdx;
  logic [NUMBER_SELWIDTH-1:0]  candIdx;
  logic [NUMBER_DATAWIDTH-1:0] grantData;
  logic [NUMBER_CHANNELS-1:0]  readyVec;
  logic                        load;

  assign load = ~validQ | bus.CC_MUX_RR_ready_In;

  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    candIdx    = '0;
    grantData  = '0;
    if (!bus.CC_MUX_RR_mode_In) begin
      if (bus.CC_MUX_RR_valid_InBUS[bus.CC_MUX_RR_select_InBUS]) begin
        grantValid = 1'b1;
        grantIdx   = bus.CC_MUX_RR_select_InBUS;
      end
    end else begin
      // Search starts at ptr; the power-of-two width makes the wrap implicit.
      for (int i = 0; i < int'(NUMBER_CHANNELS); i++) begin
        candIdx = ptrQ + NUMBER_SELWIDTH'(i);
        if (!grantValid && bus.CC_MUX_RR_valid_InBUS[candIdx]) begin
          grantValid = 1'b1;
          grantIdx   = candIdx;
        end
      end
    end
    for (int i = 0; i < int'(NUMBER_CHANNELS); i++) begin
      if (grantIdx == NUMBER_SELWIDTH'(i)) begin
        grantData = bus.CC_MUX_RR_data_InBUS[i*NUMBER_DATAWIDTH +: NUMBER_DATAWIDTH];
      end
    end
  end

  // Reset gates ready so no channel sees a handshake while held in reset.
  always_comb begin
    readyVec = '0;
    for (int i = 0; i < int'(NUMBER_CHANNELS); i++) begin
      readyVec[i] = CC_MUX_RR_RESET_InLow & load & grantValid &
                    (grantIdx == NUMBER_SELWIDTH'(i));
    end
  end

  always_comb begin
    ptrD   = ptrQ;
    chanD  = chanQ;
    zD     = zQ;
    validD = validQ;
    if (load) begin
      if (grantValid) begin
        zD     = grantData;
        chanD  = grantIdx;
        validD = 1'b1;
        if (bus.CC_MUX_RR_mode_In) begin
          ptrD = grantIdx + NUMBER_SELWIDTH'(1);
        end
      end else begin
        validD = 1'b0;
      end
    end
  end

  always_ff @(posedge CC_MUX_RR_CLOCK_50 or negedge CC_MUX_RR_RESET_InLow) begin
    if (!CC_MUX_RR_RESET_InLow) begin
      ptrQ   <= '0;
      chanQ  <= '0;
      zQ     <= '0;
      validQ <= 1'b0;
    end else begin
      ptrQ   <= ptrD;
      chanQ  <= chanD;
      zQ     <= zD;
      validQ <= validD;
    end
  end

  assign bus.CC_MUX_RR_ready_OutBUS = readyVec;
  assign bus.CC_MUX_RR_z_Out        = zQ;
  assign bus.CC_MUX_RR_channel_Out  = chanQ;
  assign bus.CC_MUX_RR_valid_Out    = validQ;

endmodule

// File: doc/cc_mux_rr.md
CC_MUX_RR -- requirements
Module: CC_MUX_RR

Interface
REQ-001 The block SHALL have parameter NUMBER_DATAWIDTH, default 8, giving the bit width of each data channel.
REQ-002 The block SHALL have parameter NUMBER_CHANNELS, default 4, giving the number of input channels; legal values are powers of two, 2..16.
REQ-003 The block SHALL have parameter NUMBER_SELWIDTH, default 2, giving the select/channel-index width; it equals log2(NUMBER_CHANNELS).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, declared before all other ports.
REQ-005 CC_MUX_RR_CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-006 CC_MUX_RR_RESET_InLow  input  1  asynchronous, active-low reset.
REQ-007 CC_MUX_RR_mode_In  input  1  0 = fixed select, 1 = round-robin.
REQ-008 CC_MUX_RR_select_InBUS  input  NUMBER_SELWIDTH  channel index used in fixed mode.
REQ-009 CC_MUX_RR_data_InBUS  input  NUMBER_CHANNELS*NUMBER_DATAWIDTH  packed channel data; channel i occupies bits [i*W +: W].
REQ-010 CC_MUX_RR_valid_InBUS  input  NUMBER_CHANNELS  per-channel valid.
REQ-011 CC_MUX_RR_ready_OutBUS  output  NUMBER_CHANNELS  per-channel ready; combinational.
REQ-012 CC_MUX_RR_z_Out  output  NUMBER_DATAWIDTH  registered output data.
REQ-013 CC_MUX_RR_channel_Out  output  NUMBER_SELWIDTH  registered index of the channel that produced CC_MUX_RR_z_Out.
REQ-014 CC_MUX_RR_valid_Out  output  1  registered output valid.
REQ-015 CC_MUX_RR_ready_In  input  1  downstream ready.

Function
REQ-016 load SHALL be defined as (~valid_Out | ready_In).
REQ-017 In mode 0, the grant SHALL be channel select_InBUS when valid_InBUS[select] = 1; otherwise there is no grant.
REQ-018 In mode 1, the grant SHALL be the first channel with valid = 1, searching ptr, ptr+1, ..., wrapping modulo NUMBER_CHANNELS; if no channel is valid there is no grant.
REQ-019 ready_OutBUS[i] SHALL be 1 only when load = 1, a grant exists, and the grant is channel i; at most one bit is set at a time.
REQ-020 A channel transfer SHALL occur on a clock edge where valid_InBUS[i] and ready_OutBUS[i] are both 1.
REQ-021 On a transfer, the next edge SHALL set z_Out = data of the granted channel, channel_Out = grant index, and valid_Out = 1; latency is 1 cycle.
REQ-022 When load = 1 and there is no grant, valid_Out SHALL go to 0 on the next edge; z_Out and channel_Out hold their values.
REQ-023 When valid_Out = 1 and ready_In = 0, z_Out, channel_Out and valid_Out SHALL hold unchanged, and all ready_OutBUS bits are 0.
REQ-024 Throughput SHALL be one transfer per cycle while ready_In = 1 and a grant exists (output consumed and refilled on the same edge).
REQ-025 The round-robin pointer ptr SHALL update to (grant+1) mod NUMBER_CHANNELS on each transfer made in mode 1, wrapping from NUMBER_CHANNELS-1 to 0.
REQ-026 ptr SHALL hold its value in mode 0 and on cycles with no transfer.
REQ-027 A change of mode_In or select_InBUS SHALL take effect in the same cycle's grant; it never alters a word already registered at the output.
REQ-028 Data on non-granted channels SHALL be ignored; a channel is never dropped once its transfer has occurred.

Reset
REQ-029 While RESET_InLow = 0, asynchronously: valid_Out = 0, z_Out = 0, channel_Out = 0, ptr = 0, and ready_OutBUS = all zeros regardless of other inputs.
REQ-030 Reset asserted mid-stream SHALL discard any registered word; after release, the first arbitration starts from ptr = 0.
REQ-031 The first transfer after reset release SHALL occur no earlier than the first rising edge with RESET_InLow = 1.

Verification
REQ-032 Fixed mode: mode 0, select = 2, all valids = 1, channel 2 data = 0xA5, ready_In = 1 -> ready_OutBUS = 4'b0100; next cycle z_Out = 0xA5, channel_Out = 2, valid_Out = 1.
REQ-033 Round-robin fairness: mode 1, valids = 4'b1111, ready_In = 1 for 8 cycles -> channel_Out sequence 0,1,2,3,0,1,2,3.
REQ-034 Round-robin skip and wrap: mode 1, ptr = 3, valids = 4'b0101 -> grant channel 0, then 2, then 0; channel 3 is never granted.
REQ-035 Backpressure: valid_Out = 1 with z_Out = 0x3C, ready_In held 0 for 5 cycles -> z_Out stays 0x3C and ready_OutBUS = 0 throughout; on ready_In = 1, the next word loads on the same edge.
REQ-036 Drain: valids go to 0 while ready_In = 1 -> valid_Out = 0 one cycle later, and z_Out retains its last value.
REQ-037 Reset mid-stream: assert RESET_InLow = 0 asynchronously between edges with valid_Out = 1 -> outputs clear immediately; after release with valids = 4'b1111 in mode 1, the first channel_Out = 0.
